// File: rtl/clause_monitor.sv
// clause_monitor: two-stage unsat-clause counter with progress tracking, solved detection
// and LFSR-driven stochastic-gate threshold regeneration on stagnation.
module clause_monitor #(
   parameter int          NUM_CLAUSES = 80,
   parameter int          STALE_LIMIT = 100000,
   parameter int          SG1_INIT    = 10,
   parameter int          SG2_INIT    = 10,
   parameter int          SG3_INIT    = 90,
   parameter logic [15:0] LFSR_SEED   = 16'h000F,
   localparam int         CW          = $clog2(NUM_CLAUSES + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_CLAUSES-1:0] clause_in,
   input  logic                   clause_valid,
   output logic [CW-1:0]          unsat_count,
   output logic                   unsat_valid,
   output logic [CW-1:0]          global_min,
   output logic                   solved,
   output logic [9:0]             sg1,
   output logic [9:0]             sg2,
   output logic [9:0]             sg3,
   output logic                   sg_update,
   output logic                   led0,
   output logic                   led1,
   output logic                   led2,
   output logic                   led3,
   output logic                   led1_b
);
   localparam int          NCH  = (NUM_CLAUSES + 7) / 8;
   localparam int          SW   = $clog2(STALE_LIMIT + 1);
   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;

   function automatic logic [9:0] fold(input logic [9:0] v);
      return (v >= 10'd1000) ? v - 10'd1000 : v;
   endfunction

   logic [NCH*8-1:0] padded;
   logic [3:0]       part_d [NCH];
   logic [3:0]       part_q [NCH];
   logic             v1_q;
   logic [CW-1:0]    sat, u;
   logic [CW-1:0]    cnt_q, cnt_d, gmin_q, gmin_d, prev_q, prev_d;
   logic             uv_q, solved_q, solved_d, sgu_q, sgu_d, led1b_q, led1b_d;
   logic [SW-1:0]    stale_q, stale_d;
   logic [9:0]       sg1_q, sg1_d, sg2_q, sg2_d, sg3_q, sg3_d;
   logic [3:0]       led_q, led_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic             upd, worse, hit;

   assign padded = (NCH*8)'(clause_in);

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         part_d[c] = '0;
         for (int b = 0; b < 8; b++) part_d[c] = part_d[c] + 4'(padded[c*8+b]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
         for (int c = 0; c < NCH; c++) part_q[c] <= '0;
      end else begin
         v1_q <= clause_valid;
         for (int c = 0; c < NCH; c++) part_q[c] <= part_d[c];
      end
   end

   always_comb begin
      sat = '0;
      for (int c = 0; c < NCH; c++) sat = sat + CW'(part_q[c]);
   end

   // Progress/stale decisions use the stage-2 count combinationally so they land with unsat_valid.
   always_comb begin
      u        = CW'(NUM_CLAUSES) - sat;
      upd      = v1_q && !solved_q;
      worse    = u >= prev_q;
      hit      = upd && worse && (u != '0) && (stale_q == SW'(STALE_LIMIT - 1));
      cnt_d    = v1_q ? u : cnt_q;
      prev_d   = v1_q ? u : prev_q;
      gmin_d   = (v1_q && u < gmin_q) ? u : gmin_q;
      solved_d = solved_q || (v1_q && u == '0);
      led_d    = v1_q ? {u > CW'(NUM_CLAUSES/75), u > CW'(NUM_CLAUSES/50),
                         u > CW'(NUM_CLAUSES/25), u > CW'(NUM_CLAUSES/5)} : led_q;
      stale_d  = !upd ? stale_q : (!worse || hit) ? '0 : stale_q + 1'b1;
      led1b_d  = !upd ? led1b_q : !worse ? 1'b0 : hit ? 1'b1 : led1b_q;
      sgu_d    = hit;
      sg1_d    = hit ? fold(lfsr_q[9:0]) : sg1_q;
      sg2_d    = hit ? fold(lfsr_q[15:6]) : sg2_q;
      sg3_d    = hit ? fold({lfsr_q[4:0], lfsr_q[15:11]}) : sg3_q;
      lfsr_d   = solved_q ? lfsr_q
                          : {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= CW'(NUM_CLAUSES);
         gmin_q   <= CW'(NUM_CLAUSES);
         prev_q   <= CW'(NUM_CLAUSES);
         uv_q     <= 1'b0;
         solved_q <= 1'b0;
         stale_q  <= '0;
         sg1_q    <= 10'(SG1_INIT);
         sg2_q    <= 10'(SG2_INIT);
         sg3_q    <= 10'(SG3_INIT);
         sgu_q    <= 1'b0;
         led_q    <= '0;
         led1b_q  <= 1'b0;
         lfsr_q   <= SEED;
      end else begin
         cnt_q    <= cnt_d;
         gmin_q   <= gmin_d;
         prev_q   <= prev_d;
         uv_q     <= v1_q;
         solved_q <= solved_d;
         stale_q  <= stale_d;
         sg1_q    <= sg1_d;
         sg2_q    <= sg2_d;
         sg3_q    <= sg3_d;
         sgu_q    <= sgu_d;
         led_q    <= led_d;
         led1b_q  <= led1b_d;
         lfsr_q   <= lfsr_d;
      end
   end

   assign unsat_count = cnt_q;
   assign unsat_valid = uv_q;
   assign global_min  = gmin_q;
   assign solved      = solved_q;
   assign sg1         = sg1_q;
   assign sg2         = sg2_q;
   assign sg3         = sg3_q;
   assign sg_update   = sgu_q;
   assign {led3, led2, led1, led0} = led_q;
   assign led1_b      = led1b_q;
endmodule

// File: tb/tb_clause_monitor.sv
// tb_clause_monitor: directed checks of counting, minimum, solved, LEDs, stale reload and reset flush.
module tb_clause_monitor;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [79:0] clause_in = '0;
   logic        clause_valid = 1'b0;
   logic [6:0]  unsat_count, global_min;
   logic        unsat_valid, solved, sg_update, led0, led1, led2, led3, led1_b;
   logic [9:0]  sg1, sg2, sg3;
   logic [15:0] m_lfsr, m_prev;
   int          n_chk = 0;
   int          n_fail = 0;

   clause_monitor #(.NUM_CLAUSES(80), .STALE_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .clause_in(clause_in), .clause_valid(clause_valid),
      .unsat_count(unsat_count), .unsat_valid(unsat_valid), .global_min(global_min),
      .solved(solved), .sg1(sg1), .sg2(sg2), .sg3(sg3), .sg_update(sg_update),
      .led0(led0), .led1(led1), .led2(led2), .led3(led3), .led1_b(led1_b)
   );

   always #5 clk = ~clk;

   // Reference LFSR; m_prev is the value the DUT held during the cycle just completed.
   always @(posedge clk) begin
      m_prev <= m_lfsr;
      m_lfsr <= rst ? 16'h000F : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   function automatic logic [9:0] fold(input logic [9:0] v);
      return (v >= 10'd1000) ? v - 10'd1000 : v;
   endfunction

   function automatic logic [79:0] mask(input int s);
      logic [79:0] m = '0;
      for (int i = 0; i < s; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_reset();
      check("rst_uv", unsat_valid, 0);
      check("rst_u", unsat_count, 80);
      check("rst_gmin", global_min, 80);
      check("rst_solved", solved, 0);
      check("rst_sg1", sg1, 10);
      check("rst_sg2", sg2, 10);
      check("rst_sg3", sg3, 90);
      check("rst_sgu", sg_update, 0);
      check("rst_leds", {led3, led2, led1, led0}, 0);
      check("rst_led1b", led1_b, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clause_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_reset();
   endtask

   task automatic drive(input int sat, input logic v);
      @(negedge clk);
      clause_in = v ? mask(sat) : '0;
      clause_valid = v;
   endtask

   // n identical samples; outputs checked two negedges after each drive.
   task automatic run(input int sat, input int n, input int pulse_at);
      for (int t = 0; t < n + 2; t++) begin
         drive(sat, t < n);
         if (t >= 2) begin
            check("uv", unsat_valid, 1);
            check("u", unsat_count, 80 - sat);
            check("sgu", sg_update, (t - 2) == pulse_at);
            if ((t - 2) == pulse_at) begin
               check("sg1", sg1, fold(m_prev[9:0]));
               check("sg2", sg2, fold(m_prev[15:6]));
               check("sg3", sg3, fold({m_prev[4:0], m_prev[15:11]}));
            end
         end
      end
      drive(0, 1'b0);
      check("uv_idle", unsat_valid, 0);
   endtask

   initial begin
      // Test 1: all clauses satisfied
      do_reset();
      run(80, 1, -1);
      check("t1_solved", solved, 1);
      check("t1_gmin", global_min, 0);
      check("t1_leds", {led3, led2, led1, led0}, 0);
      // Test 2: improving samples 60/76/79 sat
      do_reset();
      drive(60, 1'b1);
      drive(76, 1'b1);
      drive(79, 1'b1);
      check("t2_u0", unsat_count, 20);
      check("t2_led0_0", led0, 1);
      check("t2_led1_0", led1, 1);
      drive(0, 1'b0);
      check("t2_u1", unsat_count, 4);
      check("t2_led0_1", led0, 0);
      check("t2_led1_1", led1, 1);
      check("t2_led3_1", led3, 1);
      drive(0, 1'b0);
      check("t2_u2", unsat_count, 1);
      check("t2_led0_2", led0, 0);
      check("t2_led1_2", led1, 0);
      check("t2_led2_2", led2, 0);
      check("t2_gmin", global_min, 1);
      check("t2_led1b", led1_b, 0);
      // Test 3: priming sample, then five stale samples; reload on the 4th
      do_reset();
      run(70, 1, -1);
      run(70, 5, 3);
      check("t3_led1b", led1_b, 1);
      check("t3_gmin", global_min, 10);
      // Test 4: improvement clears stale state; next reload needs four more stale samples
      run(72, 1, -1);
      check("t4_led1b", led1_b, 0);
      check("t4_gmin", global_min, 8);
      run(72, 4, 3);
      check("t4_led1b_again", led1_b, 1);
      // Test 5: reset with two samples in flight
      drive(60, 1'b1);
      drive(60, 1'b1);
      rst = 1'b1;
      drive(0, 1'b0);
      check_reset();
      drive(0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b0);
         check("t5_flush_uv", unsat_valid, 0);
      end
      check_reset();
      // Test 6: solved freezes SG and stale logic while counting continues
      do_reset();
      run(80, 1, -1);
      check("t6_solved0", solved, 1);
      run(50, 10, -1);
      check("t6_u", unsat_count, 30);
      check("t6_gmin", global_min, 0);
      check("t6_solved", solved, 1);
      check("t6_sg1", sg1, 10);
      check("t6_sg2", sg2, 10);
      check("t6_sg3", sg3, 90);
      check("t6_led1b", led1_b, 0);
      check("t6_led0", led0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
